// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority over a
// FIFO of long-latency results (B); a starvation counter forces B through.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        write_enable,
  output logic [4:0]  addr_rd,
  output logic [31:0] data_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic fifo_nonempty;
  logic fifo_full;
  logic force_b;
  logic grant_a;
  logic pop;
  logic push;

  always_comb begin
    fifo_nonempty = (count != '0);
    fifo_full     = (count == CW'(DEPTH));
    force_b       = fifo_nonempty && (starve_cnt == SW'(STARVE_LIMIT));
    a_ready       = !reset && !force_b;
    b_ready       = !reset && !fifo_full;
    grant_a       = a_valid && a_ready;
    pop           = !reset && !grant_a && fifo_nonempty;
    push          = b_valid && b_ready;
  end

  // Busy lookup scans only the occupied slots, walking forward from the head.
  always_comb begin
    logic [PW-1:0] idx;
    logic          hit1;
    logic          hit2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + i[PW-1:0];
      if (i < 32'(count)) begin
        if (rd_q[idx] == chk_rs1) hit1 = 1'b1;
        if (rd_q[idx] == chk_rs2) hit2 = 1'b1;
      end
    end
    if (write_enable && addr_rd == chk_rs1) hit1 = 1'b1;
    if (write_enable && addr_rd == chk_rs2) hit2 = 1'b1;
    rs1_busy = !reset && (chk_rs1 != '0) && hit1;
    rs2_busy = !reset && (chk_rs2 != '0) && hit2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      starve_cnt   <= '0;
      write_enable <= 1'b0;
      addr_rd      <= '0;
      data_rd      <= '0;
    end else begin
      if (push) begin
        rd_q[wr_ptr]   <= b_rd;
        data_q[wr_ptr] <= b_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (grant_a) begin
        write_enable <= (a_rd != '0);
        addr_rd      <= a_rd;
        data_rd      <= a_data;
      end else if (pop) begin
        write_enable <= (rd_q[rd_ptr] != '0);
        addr_rd      <= rd_q[rd_ptr];
        data_rd      <= data_q[rd_ptr];
      end else begin
        write_enable <= 1'b0;
      end

      // Counts only A wins that left a queued B entry waiting.
      if (pop || !fifo_nonempty)
        starve_cnt <= '0;
      else if (grant_a && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, chk_rs1, chk_rs2, addr_rd;
  logic [31:0] a_data, b_data, data_rd;
  logic        rs1_busy, rs2_busy, write_enable;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         q[$];
  int          starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          checks = 0;
  int          errors = 0;
  logic        seen_a_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_flight(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_we && m_addr == r) return 1'b1;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, check against the model, then advance both.
  task automatic step(input logic rst, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic bv, input logic [4:0] brd,
                      input logic [31:0] bd, input logic [4:0] c1, input logic [4:0] c2);
    logic ne, ea, eb, ga, gb, pu;
    wb_t  h;
    reset = rst; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd; chk_rs1 = c1; chk_rs2 = c2;
    #1;
    ne = (q.size() != 0);
    ea = !rst && !(ne && starve == STARVE_LIMIT);
    eb = !rst && (q.size() < DEPTH);
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("rs1_busy", 32'(rs1_busy), 32'(!rst && in_flight(c1)));
    chk("rs2_busy", 32'(rs2_busy), 32'(!rst && in_flight(c2)));
    chk("write_enable", 32'(write_enable), 32'(m_we));
    chk("addr_rd", 32'(addr_rd), 32'(m_addr));
    chk("data_rd", data_rd, m_data);
    seen_a_ready = a_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      ga = av && ea;
      gb = !ga && ne;
      pu = bv && eb;
      if (ga) begin
        m_we = (ard != 0); m_addr = ard; m_data = ad;
      end else if (gb) begin
        h = q.pop_front();
        m_we = (h.rd != 0); m_addr = h.rd; m_data = h.data;
      end else begin
        m_we = 1'b0;
      end
      if (gb || !ne) starve = 0;
      else if (ga && starve < STARVE_LIMIT) starve++;
      if (pu) q.push_back('{rd: brd, data: bd});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, c1, c2);
  endtask

  initial begin
    int lows;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_rd = '0; b_rd = '0;
    a_data = '0; b_data = '0; chk_rs1 = '0; chk_rs2 = '0;
    q.delete(); starve = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state and idle
    step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, 5'd3, 5'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_addr", 32'(addr_rd), 32'd0);
    chk("rst_data", data_rd, 32'd0);
    idle(5'd0, 5'd0);
    chk("idle_a_ready", 32'(a_ready), 32'd1);
    chk("idle_b_ready", 32'(b_ready), 32'd1);

    // A write latency and x0 suppression
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("a_we", 32'(write_enable), 32'd1);
    chk("a_addr", 32'(addr_rd), 32'd5);
    chk("a_data", data_rd, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("x0_we", 32'(write_enable), 32'd0);

    // Fill FIFO with A blocking pops, then drain in order
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'd1);
    chk("full_b_ready", 32'(b_ready), 32'd0);
    for (int i = 1; i <= 5; i++) idle(5'(i), 5'd4);

    // Starvation: A valid every cycle, one B entry queued
    lows = 0;
    step(1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd7, 32'h77, 5'd7, 5'd10);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 5'(11 + i), 32'hA1 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd7, 5'(11 + i));
      if (!seen_a_ready) lows++;
    end
    chk("starve_low_cycles", 32'(lows), 32'd1);

    // Reset with 3 entries queued discards them
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h200 + 32'(i), 5'd20, 5'd21);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd22);
    for (int i = 0; i < 4; i++) begin
      idle(5'd20, 5'd22);
      chk("post_rst_we", 32'(write_enable), 32'd0);
      chk("post_rst_busy", 32'(rs1_busy), 32'd0);
    end

    // Push+pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'h300 + 32'(i), 5'd8, 5'd9);
    for (int i = 2; i < 12; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'h300 + 32'(i), 5'(8 + i), 5'(6 + i));
      chk("steady_b_ready", 32'(b_ready), 32'd1);
    end
    repeat (3) idle(5'd0, 5'd0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60),
           5'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
